// File: rtl/mon_prod_ctl.sv
// Radix-2 bit-serial Montgomery multiplier: P = A*B*2^-n mod M, fully reduced.
// One iteration per cycle, then a single conditional-subtraction cycle.
module mon_prod_ctl #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  input  logic [CNT_W-1:0] mp_count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P
);

  typedef enum logic [1:0] {IDLE, LOOP, FINAL} state_t;

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic [WIDTH-1:0] m_r_q, m_r_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] n_eff;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] t_sum;
  logic [WIDTH+1:0] t_red;

  // Requests longer than the operand are clamped so only WIDTH bits of A are scanned.
  assign n_eff = (mp_count > WIDTH_CNT) ? WIDTH_CNT : mp_count;

  // Two guard bits: acc < 2M, plus B < M, plus M stays below 4M.
  assign m_ext = {2'b00, m_r_q};
  assign t_sum = acc_q + (a_sh_q[0] ? {2'b00, b_r_q} : '0);
  assign t_red = t_sum[0] ? (t_sum + m_ext) : t_sum;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_r_d   = b_r_q;
    m_r_d   = m_r_q;
    p_d     = p_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_r_d   = B;
          m_r_d   = M;
          acc_d   = '0;
          cnt_d   = n_eff;
          busy_d  = 1'b1;
          state_d = (n_eff != '0) ? LOOP : FINAL;
        end
      end
      LOOP: begin
        acc_d  = t_red >> 1;
        a_sh_d = a_sh_q >> 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        p_d     = WIDTH'((acc_q >= m_ext) ? (acc_q - m_ext) : acc_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_r_q   <= '0;
      m_r_q   <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_r_q   <= b_r_d;
      m_r_q   <= m_r_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_mon_prod_ctl.sv
// Directed bench for mon_prod_ctl: a 1024-bit instance and an 8-bit instance
// sharing clock and reset, checked against hand-computed Montgomery products.
module tb_mon_prod_ctl;

  localparam int W   = 1024;
  localparam int CW  = 11;
  localparam int W8  = 8;
  localparam int CW8 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [W-1:0]  a, b, m, p;
  logic [CW-1:0] mpc;
  logic          busy, done;

  logic           start8;
  logic [W8-1:0]  a8, b8, m8, p8;
  logic [CW8-1:0] mpc8;
  logic           busy8, done8;

  int errors = 0;
  int checks = 0;

  mon_prod_ctl #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .A(a), .B(b), .M(m), .mp_count(mpc),
    .busy(busy), .done(done), .P(p)
  );

  mon_prod_ctl #(.WIDTH(W8), .CNT_W(CW8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .A(a8), .B(b8), .M(m8), .mp_count(mpc8),
    .busy(busy8), .done(done8), .P(p8)
  );

  // Issue one start on the wide instance and wait (bounded) for done.
  // Called #1 after a posedge; returns #1 after the edge that raised done.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [W-1:0] mi, input logic [CW-1:0] ni,
                        output int lat, output int busy_cyc);
    a = ai; b = bi; m = mi; mpc = ni; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 3000) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    $display("op W=%0d A=%0d B=%0d M=%0d n=%0d -> P=%0d latency=%0d busy=%0d",
             W, ai, bi, mi, ni, p, lat, busy_cyc);
  endtask

  task automatic run_op8(input logic [W8-1:0] ai, input logic [W8-1:0] bi,
                         input logic [W8-1:0] mi, input logic [CW8-1:0] ni,
                         output int lat);
    a8 = ai; b8 = bi; m8 = mi; mpc8 = ni; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op W=%0d A=%0d B=%0d M=%0d n=%0d -> P=%0d latency=%0d",
             W8, ai, bi, mi, ni, p8, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; m = '0; mpc = '0;
    a8 = '0; b8 = '0; m8 = '0; mpc8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_wide: busy=%b done=%b P=%0d required 0 0 0", busy, done, p);
    end
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== '0) begin
      errors++;
      $display("FAIL reset_narrow: busy=%b done=%b P=%0d required 0 0 0", busy8, done8, p8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    run_op(571, 435, 589, 10, lat, bc);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL basic_latency: got %0d required 11", lat); end
    checks++;
    if (bc !== 11) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 11", bc); end
    checks++;
    if (p !== 571) begin errors++; $display("FAIL basic_p: got %0d required 571", p); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b required 0 0", done, busy);
    end
    run_op(588, 588, 589, 10, lat, bc);
    checks++;
    if (p !== 218) begin errors++; $display("FAIL minus1_p: got %0d required 218", p); end
    checks++;
    if (!(p < 589)) begin errors++; $display("FAIL minus1_reduced: got %0d required below 589", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    int lat, bc;
    run_op(571, 435, 589, 0, lat, bc);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d required 1", lat); end
    checks++;
    if (p !== 0) begin errors++; $display("FAIL zero_p: got %0d required 0", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int lat, bc, lat8;
    run_op(3, 4, 5, 2000, lat, bc);
    checks++;
    if (lat !== 1025) begin errors++; $display("FAIL sat_latency: got %0d required 1025", lat); end
    checks++;
    if (p !== 2) begin errors++; $display("FAIL sat_p: got %0d required 2", p); end
    run_op8(5, 7, 13, 15, lat8);
    checks++;
    if (lat8 !== 9) begin errors++; $display("FAIL sat8_latency: got %0d required 9", lat8); end
    checks++;
    if (p8 !== 1) begin errors++; $display("FAIL sat8_p: got %0d required 1", p8); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, dn;
    run_op8(5, 7, 13, 4, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d required 5", lat); end
    checks++;
    if (p8 !== 3) begin errors++; $display("FAIL b2b_first_p: got %0d required 3", p8); end
    // Second start issued in the very cycle done is high.
    a8 = 3; b8 = 3; m8 = 13; mpc8 = 4; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handover: done=%b busy=%b required 0 1", done8, busy8);
    end
    lat = 0;
    dn = 0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done8) begin
        dn++;
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL b2b_second_latency: got %0d required 5", lat); end
        checks++;
        if (p8 !== 3) begin errors++; $display("FAIL b2b_second_p: got %0d required 3", p8); end
      end
    end
    $display("op W=%0d back-to-back second result P=%0d done_pulses=%0d", W8, p8, dn);
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL b2b_pulse_count: got %0d required 1", dn); end
  endtask

  task automatic test_start_ignore();
    int lat, dn, first_lat;
    logic [W-1:0] p_done;
    a = 571; b = 435; m = 589; mpc = 10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; dn = 0; first_lat = -1; p_done = '0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        dn++;
        if (first_lat < 0) begin first_lat = lat; p_done = p; end
      end
      if (lat == 3) begin a = 588; b = 588; start = 1'b1; end
      if (lat == 4) start = 1'b0;
    end
    $display("op W=%0d ignored-start P=%0d latency=%0d done_pulses=%0d", W, p_done, first_lat, dn);
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL ignore_pulse_count: got %0d required 1", dn); end
    checks++;
    if (first_lat !== 11) begin errors++; $display("FAIL ignore_latency: got %0d required 11", first_lat); end
    checks++;
    if (p_done !== 571) begin errors++; $display("FAIL ignore_p: got %0d required 571", p_done); end
    checks++;
    if (p !== 571 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_hold: P=%0d busy=%b required 571 0", p, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dn;
    a = 588; b = 588; m = 589; mpc = 10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b P=%0d required 0 0 0", busy, done, p);
    end
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    $display("op W=%0d reset mid-loop, done pulses afterwards=%0d", W, dn);
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses required 0", dn); end
    run_op(588, 588, 589, 10, lat, bc);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL midreset_fresh_latency: got %0d required 11", lat); end
    checks++;
    if (p !== 218) begin errors++; $display("FAIL midreset_fresh_p: got %0d required 218", p); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_saturation();
    test_back_to_back();
    test_start_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
